// File: rtl/cpu_pkg.sv
// Shared CPU-side types and constants.
// Holds the program-loader state encoding and release-delay limits.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2,
        S_ERR  = 2'd3
    } loader_state_t;

    localparam int LOADER_MAX_RELEASE_DLY = 15;
    localparam int LOADER_DLY_W = $clog2(LOADER_MAX_RELEASE_DLY + 1);

endpackage

// File: rtl/release_timer.sv
// Loadable down-counter with a zero flag.
// Holds at zero; a load overrides counting.
module release_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/program_loader.sv
// Streams a program into instruction memory, then releases CPU reset.
// Overflow without s_last parks in ERR until reload or rst.
module program_loader
    import cpu_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8,
    parameter int RELEASE_DLY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [LOADER_DLY_W-1:0] DLY = LOADER_DLY_W'(RELEASE_DLY);
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH_WORDS - 1);

    loader_state_t     r_state;
    logic [ADDR_W:0]   r_count;
    logic              r_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_cpu_rst;
    logic              r_done;
    logic              r_err;

    logic w_accept;
    logic w_at_end;
    logic w_zero;
    logic w_hold;

    // reload outranks a coincident beat, so it never reaches memory
    assign w_accept = s_valid & r_ready & (r_state == S_LOAD) & ~reload;
    assign w_at_end = (r_count == LAST_PTR);
    assign w_hold   = (r_state == S_HOLD);

    release_timer #(
        .W(LOADER_DLY_W)
    ) u_release_timer (
        .clk    (clk),
        .rst_n  (rst),
        .i_load (w_accept & s_last),
        .i_value(DLY),
        .i_en   (w_hold),
        .o_zero (w_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_LOAD;
            r_count   <= '0;
            r_ready   <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_we <= w_accept;
            if (w_accept) begin
                r_addr  <= r_count[ADDR_W-1:0];
                r_wdata <= s_data;
                r_count <= r_count + (ADDR_W+1)'(1);
            end
            if (reload) begin
                r_state   <= S_LOAD;
                r_count   <= '0;
                r_ready   <= 1'b1;
                r_cpu_rst <= 1'b1;
                r_done    <= 1'b0;
                r_err     <= 1'b0;
            end else begin
                unique case (r_state)
                    S_LOAD: begin
                        if (w_accept && s_last) begin
                            r_state <= S_HOLD;
                            r_ready <= 1'b0;
                        end else if (w_accept && w_at_end) begin
                            r_state <= S_ERR;
                            r_ready <= 1'b0;
                            r_err   <= 1'b1;
                        end else begin
                            r_ready <= 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (w_zero) begin
                            r_state   <= S_RUN;
                            r_cpu_rst <= 1'b0;
                            r_done    <= 1'b1;
                        end
                    end
                    S_RUN: ;
                    S_ERR: ;
                    default: ;
                endcase
            end
        end
    end

    assign s_ready    = r_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_rst    = r_cpu_rst;
    assign done       = r_done;
    assign err        = r_err;
    assign word_count = r_count;

endmodule
